mult_iter_unit: RTL and testbench

//  Iterative multi-cycle multiply/accumulate responder. The EX-stage ALU issues a request:

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_step.sv | 28 ++
 rtl/mult_iter_unit.sv | 157 +++++++++++++++
 tb/tb_mult_iter_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiply/accumulate unit.
package mult_pkg;

    localparam int unsigned MULT_W = 32;

    typedef enum logic [1:0] {
        MOP_MUL  = 2'd0,
        MOP_MADD = 2'd1,
        MOP_MSUB = 2'd2
    } mult_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mult_state_e;

    // Magnitude of an operand; 0x80000000 signed maps to 2^31 as unsigned.
    function automatic logic [MULT_W-1:0] mag(input logic [MULT_W-1:0] v, input logic sgn);
        return (sgn && v[MULT_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One iteration of the shift-add multiplier: adds mcand * bits, pre-shifted
// by the current bit position, into the running 64-bit partial product.
module mult_step
    import mult_pkg::*;
#(
    parameter int unsigned BPC = 2
) (
    input  logic [2*MULT_W-1:0] pp_i,
    input  logic [MULT_W-1:0]   mcand_i,
    input  logic [BPC-1:0]      bits_i,
    input  logic [5:0]          shift_i,
    output logic [2*MULT_W-1:0] pp_o
);

    logic [2*MULT_W-1:0] base;

    assign base = {{MULT_W{1'b0}}, mcand_i} << shift_i;

    always_comb begin
        pp_o = pp_i;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (bits_i[i]) begin
                pp_o = pp_o + (base << i);
            end
        end
    end

endmodule

// File: rtl/mult_iter_unit.sv
// Iterative MULT/MADD/MSUB responder: magnitude shift-add over ITERS cycles,
// sign and accumulate fixup on the last cycle, result held until acknowledged.
module mult_iter_unit
    import mult_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  op_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] acc_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ack_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    localparam int unsigned ITERS = MULT_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    mult_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MULT_W-1:0]    mcand_q, mcand_d;
    logic [MULT_W-1:0]    mplier_q, mplier_d;
    logic [2*MULT_W-1:0]  pp_q, pp_d;
    logic                 neg_q, neg_d;
    logic [1:0]           op_q, op_d;
    logic [2*MULT_W-1:0]  acc_q, acc_d;
    logic [MULT_W-1:0]    hi_q, hi_d;
    logic [MULT_W-1:0]    lo_q, lo_d;
    logic                 rsp_valid_q, rsp_valid_d;

    logic                 accept;
    logic [5:0]           shift;
    logic [2*MULT_W-1:0]  pp_next;
    logic [2*MULT_W-1:0]  prod;
    logic [2*MULT_W-1:0]  result;

    assign shift = 6'(cnt_q) * 6'(BITS_PER_CYCLE);

    mult_step #(
        .BPC(BITS_PER_CYCLE)
    ) u_step (
        .pp_i   (pp_q),
        .mcand_i(mcand_q),
        .bits_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .shift_i(shift),
        .pp_o   (pp_next)
    );

    assign req_ready_o = (state_q == S_IDLE) || ((state_q == S_DONE) && rsp_ack_i);
    assign accept      = req_valid_i && req_ready_o && !flush_i;

    always_comb begin
        prod = neg_q ? (~pp_next + 64'd1) : pp_next;
        if (op_q == MOP_MADD) begin
            result = acc_q + prod;
        end else if (op_q == MOP_MSUB) begin
            result = acc_q - prod;
        end else begin
            result = prod;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        pp_d        = pp_q;
        neg_d       = neg_q;
        op_d        = op_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rsp_valid_d = rsp_valid_q;

        if (flush_i) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
            cnt_d       = '0;
        end else if (accept) begin
            // Covers both IDLE accept and DONE ack with a same-cycle re-accept.
            state_d     = S_CALC;
            mcand_d     = mag(a_i, signed_i);
            mplier_d    = mag(b_i, signed_i);
            neg_d       = signed_i && (a_i[31] ^ b_i[31]);
            op_d        = op_i;
            acc_d       = acc_i;
            pp_d        = '0;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_CALC: begin
                    pp_d     = pp_next;
                    mplier_d = mplier_q >> BITS_PER_CYCLE;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d      = S_DONE;
                        rsp_valid_d  = 1'b1;
                        {hi_d, lo_d} = result;
                    end
                end
                S_DONE: begin
                    if (rsp_ack_i) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            pp_q        <= '0;
            neg_q       <= 1'b0;
            op_q        <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            pp_q        <= pp_d;
            neg_q       <= neg_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_iter_unit.sv
// Bench for mult_iter_unit: directed scenarios plus random ops against a 64-bit arithmetic model.
module tb_mult_iter_unit;

    localparam int unsigned BPC   = 2;
    localparam int unsigned ITERS = 32 / BPC;
    localparam int          LAT   = ITERS + 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ack;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] res_v;
    int          lat_v;
    bit          to_v;

    mult_iter_unit #(
        .BITS_PER_CYCLE(BPC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .op_i       (op),
        .signed_i   (sgn),
        .a_i        (a),
        .b_i        (b),
        .acc_i      (acc),
        .flush_i    (flush),
        .rsp_valid_o(rsp_valid),
        .rsp_ack_i  (rsp_ack),
        .hi_o       (hi),
        .lo_o       (lo),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width two's-complement or unsigned product, then accumulate mod 2^64.
    function automatic logic [63:0] ref_mac(input logic [1:0] o, input logic s,
                                            input logic [31:0] x, input logic [31:0] y,
                                            input logic [63:0] ac);
        logic signed [63:0] sx, sy;
        logic [63:0] p;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            p  = sx * sy;
        end else begin
            p = {32'd0, x} * {32'd0, y};
        end
        case (o)
            2'd1:    return ac + p;
            2'd2:    return ac - p;
            default: return p;
        endcase
    endfunction

    task automatic start_req(input logic [1:0] o, input logic s, input logic [31:0] x,
                             input logic [31:0] y, input logic [63:0] ac);
        op = o; sgn = s; a = x; b = y; acc = ac;
        req_valid = 1'b1;
    endtask

    // Counts cycles from the accept cycle until rsp_valid is seen (bounded).
    task automatic wait_rsp();
        lat_v = 0;
        to_v  = 1'b0;
        do begin
            @(negedge clk);
            lat_v++;
            if (lat_v == 1) begin
                req_valid = 1'b0;
                rsp_ack   = 1'b0;
            end
        end while (!rsp_valid && lat_v < 200);
        if (!rsp_valid) to_v = 1'b1;
        res_v = {hi, lo};
    endtask

    task automatic ack_rsp();
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b busy=%b hilo=%h, want 0 0 0", rsp_valid, busy, {hi, lo});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        start_req(2'd0, 1'b0, 32'd5, 32'd7, 64'd0);
        wait_rsp();
        vectors++;
        if (to_v || res_v !== 64'd35) begin
            miscompares++;
            $display("FAIL reset_pre_op: got %h want %h timeout=%0d", res_v, 64'd35, to_v);
        end
        ack_rsp();
        start_req(2'd0, 1'b1, 32'hFFFFFFFD, 32'd7, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_precalc_busy: got %b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_midcalc: valid=%b busy=%b hilo=%h, want 0 0 0", rsp_valid, busy, {hi, lo});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_unsigned_max();
        start_req(2'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
        wait_rsp();
        vectors++;
        if (to_v || lat_v != LAT) begin
            miscompares++;
            $display("FAIL umax_latency: got %0d want %0d", lat_v, LAT);
        end
        vectors++;
        if (res_v !== 64'hFFFFFFFE_00000001) begin
            miscompares++;
            $display("FAIL umax_result: got %h want %h", res_v, 64'hFFFFFFFE_00000001);
        end
        ack_rsp();
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL umax_after_ack: valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_signed();
        start_req(2'd0, 1'b1, 32'hFFFFFFFD, 32'd7, 64'd0);
        wait_rsp();
        vectors++;
        if (to_v || res_v !== 64'hFFFFFFFF_FFFFFFEB) begin
            miscompares++;
            $display("FAIL signed_neg3x7: got %h want %h", res_v, 64'hFFFFFFFF_FFFFFFEB);
        end
        ack_rsp();
        start_req(2'd0, 1'b1, 32'h80000000, 32'h80000000, 64'd0);
        wait_rsp();
        vectors++;
        if (to_v || res_v !== 64'h40000000_00000000) begin
            miscompares++;
            $display("FAIL signed_minmin: got %h want %h", res_v, 64'h40000000_00000000);
        end
        ack_rsp();
    endtask

    task automatic test_madd_msub();
        start_req(2'd1, 1'b1, 32'hFFFFFFFE, 32'd8, 64'h00000000_00000010);
        wait_rsp();
        vectors++;
        if (to_v || res_v !== 64'd0) begin
            miscompares++;
            $display("FAIL madd_signed: got %h want %h", res_v, 64'd0);
        end
        ack_rsp();
        start_req(2'd2, 1'b0, 32'd1, 32'd1, 64'd0);
        wait_rsp();
        vectors++;
        if (to_v || res_v !== 64'hFFFFFFFF_FFFFFFFF) begin
            miscompares++;
            $display("FAIL msubu: got %h want %h", res_v, 64'hFFFFFFFF_FFFFFFFF);
        end
        ack_rsp();
    endtask

    task automatic test_flush();
        logic [63:0] prev;
        bit seen;
        prev = {hi, lo};
        start_req(2'd0, 1'b0, 32'd123, 32'd456, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        start_req(2'd0, 1'b0, 32'd9, 32'd9, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || {hi, lo} !== prev) begin
            miscompares++;
            $display("FAIL flush_calc: busy=%b valid=%b hilo=%h want 0 0 %h", busy, rsp_valid, {hi, lo}, prev);
        end
        seen = 1'b0;
        repeat (ITERS + 8) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL flush_dropped: activity seen after flush, want none");
        end
        start_req(2'd0, 1'b0, 32'd1000, 32'd3000, 64'd0);
        wait_rsp();
        vectors++;
        if (to_v || lat_v != LAT || res_v !== 64'd3000000) begin
            miscompares++;
            $display("FAIL flush_recover: got %h lat %0d want %h lat %0d", res_v, lat_v, 64'd3000000, LAT);
        end
        rsp_ack = 1'b1;
        flush = 1'b1;
        start_req(2'd0, 1'b0, 32'd2, 32'd2, 64'd0);
        @(negedge clk);
        rsp_ack = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || {hi, lo} !== 64'd3000000) begin
            miscompares++;
            $display("FAIL flush_done: busy=%b valid=%b hilo=%h want 0 0 %h", busy, rsp_valid, {hi, lo}, 64'd3000000);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r1;
        start_req(2'd0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 64'd0);
        wait_rsp();
        r1 = ref_mac(2'd0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 64'd0);
        vectors++;
        if (to_v || res_v !== r1) begin
            miscompares++;
            $display("FAIL b2b_first: got %h want %h", res_v, r1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || {hi, lo} !== r1) begin
                miscompares++;
                $display("FAIL b2b_hold: valid=%b hilo=%h want 1 %h", rsp_valid, {hi, lo}, r1);
            end
        end
        rsp_ack = 1'b1;
        start_req(2'd1, 1'b1, 32'hFFFF0000, 32'h00010001, 64'h1);
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b want 1", req_ready);
        end
        wait_rsp();
        vectors++;
        if (to_v || lat_v != LAT) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d want %0d", lat_v, LAT);
        end
        vectors++;
        if (res_v !== ref_mac(2'd1, 1'b1, 32'hFFFF0000, 32'h00010001, 64'h1)) begin
            miscompares++;
            $display("FAIL b2b_second: got %h want %h", res_v,
                     ref_mac(2'd1, 1'b1, 32'hFFFF0000, 32'h00010001, 64'h1));
        end
        ack_rsp();
    endtask

    task automatic test_random();
        logic [31:0] edge_vals [6];
        logic [1:0]  ro;
        logic        rs;
        logic [31:0] ra, rb;
        logic [63:0] rc, exp_v;
        edge_vals = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        for (int n = 0; n < 400; n++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            rc = {$urandom, $urandom};
            exp_v = ref_mac(ro, rs, ra, rb, rc);
            start_req(ro, rs, ra, rb, rc);
            wait_rsp();
            vectors++;
            if (to_v || lat_v != LAT || res_v !== exp_v) begin
                miscompares++;
                $display("FAIL rand_op%0d: op=%0d s=%0d a=%h b=%h acc=%h got %h lat %0d want %h lat %0d",
                         n, ro, rs, ra, rb, rc, res_v, lat_v, exp_v, LAT);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || {hi, lo} !== exp_v) begin
                miscompares++;
                $display("FAIL rand_hold%0d: valid=%b hilo=%h want 1 %h", n, rsp_valid, {hi, lo}, exp_v);
            end
            ack_rsp();
            if ($urandom_range(0, 3) == 0) begin
                rsp_ack = 1'b1;
                @(negedge clk);
                rsp_ack = 1'b0;
                vectors++;
                if (busy !== 1'b0 || rsp_valid !== 1'b0 || {hi, lo} !== exp_v) begin
                    miscompares++;
                    $display("FAIL rand_idle_ack%0d: busy=%b valid=%b hilo=%h want 0 0 %h",
                             n, busy, rsp_valid, {hi, lo}, exp_v);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; op = '0; sgn = 1'b0;
        a = '0; b = '0; acc = '0; flush = 1'b0; rsp_ack = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_madd_msub();
        test_flush();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
